// File: rtl/tqvp_uart_tx_fifo_if.sv
// Bundle of the CPU-side write port, status flags and the transmitter
// enable/busy handshake of tqvp_uart_tx_fifo.
// Handshake: the FIFO pulses uart_tx_en for exactly one cycle with
// uart_tx_data valid in that cycle. The transmitter answers by raising
// uart_tx_busy from the following cycle until its frame is done. The FIFO
// issues no new uart_tx_en until it has seen uart_tx_busy low again.
// feeder_state is a debug view of the feeder FSM: 0=IDLE, 1=SENT, 2=WAIT.
interface tqvp_uart_tx_fifo_if #(
    parameter int PAYLOAD_BITS = 8,
    parameter int LEVEL_BITS   = 4
);
    logic                    wr_en;
    logic [PAYLOAD_BITS-1:0] wr_data;
    logic                    clear_overflow;
    logic                    full;
    logic                    empty;
    logic [LEVEL_BITS-1:0]   level;
    logic                    overflow;
    logic                    tx_irq;
    logic                    uart_tx_en;
    logic [PAYLOAD_BITS-1:0] uart_tx_data;
    logic                    uart_tx_busy;
    logic [1:0]              feeder_state;

    // CPU / transmitter side
    modport master (
        output wr_en, wr_data, clear_overflow, uart_tx_busy,
        input  full, empty, level, overflow, tx_irq,
        input  uart_tx_en, uart_tx_data, feeder_state
    );

    // FIFO side
    modport slave (
        input  wr_en, wr_data, clear_overflow, uart_tx_busy,
        output full, empty, level, overflow, tx_irq,
        output uart_tx_en, uart_tx_data, feeder_state
    );
endinterface

// File: rtl/tqvp_uart_tx_fifo.sv
// Transmit byte FIFO for the tinyQV UART: the CPU pushes bytes, a three-state
// feeder (IDLE/SENT/WAIT) hands them one at a time to the transmitter.
// Optional low-watermark interrupt: define UART_TX_FIFO_IRQ_EN to build it;
// otherwise tx_irq is tied to 0.
module tqvp_uart_tx_fifo #(
    parameter int DEPTH         = 8,
    parameter int PAYLOAD_BITS  = 8,
    parameter int LEVEL_BITS    = 4,
    parameter int IRQ_THRESHOLD = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    tqvp_uart_tx_fifo_if.slave     bus
);
    localparam int PTR_BITS = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SENT = 2'd1,
        ST_WAIT = 2'd2
    } feeder_state_e;

    logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
    logic [PTR_BITS-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LEVEL_BITS-1:0]   level_q, level_d;
    logic                    empty_q, empty_d;
    logic                    full_q, full_d;
    logic                    overflow_q, overflow_d;
    logic                    tx_en_q, tx_en_d;
    logic [PAYLOAD_BITS-1:0] tx_data_q, tx_data_d;
    feeder_state_e           state_q, state_d;
    logic                    push, pop, drop;

    // Write acceptance uses the registered full flag, so a write while full is
    // dropped even if the feeder pops on the same edge.
    assign push = bus.wr_en && !full_q;
    assign drop = bus.wr_en && full_q;

    // Feeder FSM: pop one byte when the transmitter is idle, pulse enable,
    // then skip a cycle (busy lags enable) and wait for busy to clear.
    always_comb begin
        state_d   = state_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_q && !bus.uart_tx_busy) begin
                    pop       = 1'b1;
                    tx_en_d   = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = ST_SENT;
                end
            end
            ST_SENT: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!bus.uart_tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pointer, occupancy and sticky overflow next-state.
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;
        level_d    = level_q + LEVEL_BITS'(push) - LEVEL_BITS'(pop);
        empty_d    = (level_d == '0);
        full_d     = (level_d == LEVEL_BITS'(DEPTH));
        overflow_d = overflow_q;
        if (bus.clear_overflow) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage array; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

`ifdef UART_TX_FIFO_IRQ_EN
    logic tx_irq_q;
    logic tx_irq_d;

    // Compare against the next level so the interrupt moves on the same edge
    // as level itself.
    assign tx_irq_d = (level_d <= LEVEL_BITS'(IRQ_THRESHOLD));

    // Registered low-watermark interrupt, held low on the reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_irq_q <= 1'b0;
        end else begin
            tx_irq_q <= tx_irq_d;
        end
    end

    assign bus.tx_irq = tx_irq_q;
`else
    // Threshold only matters for the interrupt build; tie it off here.
    logic unused_irq_threshold;
    assign unused_irq_threshold = ^IRQ_THRESHOLD;
    assign bus.tx_irq           = 1'b0;
`endif

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.level        = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.uart_tx_en   = tx_en_q;
    assign bus.uart_tx_data = tx_data_q;
    assign bus.feeder_state = state_q;
endmodule
